// File: rtl/max_row_scheduler.sv
// Row-max scheduler: folds per-chunk signed local maxima into one row maximum
// and hands it downstream with a valid/ready handshake.
module max_row_scheduler #(
  parameter int DATA_W     = 16,
  parameter int MAX_CHUNKS = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [3:0]        i_num_chunks,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_loc_max,
  output logic [3:0]        o_chunk_idx,
  output logic [DATA_W-1:0] o_row_max,
  output logic              o_row_valid,
  input  logic              i_row_ready,
  output logic              o_busy,
  output logic              o_err,
  output logic [7:0]        o_rows_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]        state;
  logic [3:0]        n_reg;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] row_max;
  logic              err_q;
  logic [7:0]        rows_done;

  logic              num_legal;
  logic              can_start;
  logic              start_ok;
  logic              start_bad;
  logic              hs;
  logic              last_chunk;
  logic [DATA_W-1:0] max_val;

  // A new row may begin from IDLE, or from OUT in the cycle the row is released.
  always_comb begin
    num_legal  = (i_num_chunks != 4'd0) && (i_num_chunks <= 4'(MAX_CHUNKS));
    can_start  = (state == ST_IDLE) || ((state == ST_OUT) && i_row_ready);
    start_ok   = i_start && num_legal && can_start;
    start_bad  = i_start && !num_legal && can_start;
    hs         = (state == ST_ACCUM) && i_in_valid;
    last_chunk = (cnt == n_reg - 4'd1);
    max_val    = ($signed(i_loc_max) > $signed(acc)) ? i_loc_max : acc;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      n_reg     <= '0;
      cnt       <= '0;
      acc       <= MIN_VAL;
      row_max   <= MIN_VAL;
      err_q     <= 1'b0;
      rows_done <= '0;
    end else begin
      err_q <= start_bad;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            n_reg <= i_num_chunks;
            cnt   <= '0;
            acc   <= MIN_VAL;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (hs) begin
            acc <= max_val;
            cnt <= cnt + 4'd1;
            if (last_chunk) begin
              row_max <= max_val;
              state   <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (i_row_ready) begin
            rows_done <= rows_done + 8'd1;
            if (start_ok) begin
              n_reg <= i_num_chunks;
              cnt   <= '0;
              acc   <= MIN_VAL;
              state <= ST_ACCUM;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_in_ready  = (state == ST_ACCUM);
    o_chunk_idx = (state == ST_ACCUM) ? cnt : 4'd0;
    o_row_max   = row_max;
    o_row_valid = (state == ST_OUT);
    o_busy      = (state != ST_IDLE);
    o_err       = err_q;
    o_rows_done = rows_done;
  end

endmodule

// File: tb/tb_max_row_scheduler.sv
// Bench for max_row_scheduler: table of rows with hand-computed maxima feeding a
// scoreboard queue, plus directed sequences for error, stall, reset and wrap cases.
module tb_max_row_scheduler;

  localparam int DATA_W     = 16;
  localparam int MAX_CHUNKS = 12;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_start;
  logic [3:0]        i_num_chunks;
  logic              i_in_valid;
  logic              o_in_ready;
  logic [DATA_W-1:0] i_loc_max;
  logic [3:0]        o_chunk_idx;
  logic [DATA_W-1:0] o_row_max;
  logic              o_row_valid;
  logic              i_row_ready;
  logic              o_busy;
  logic              o_err;
  logic [7:0]        o_rows_done;

  always #5 i_clk = ~i_clk;

  max_row_scheduler #(.DATA_W(DATA_W), .MAX_CHUNKS(MAX_CHUNKS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_chunks(i_num_chunks),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_loc_max(i_loc_max),
    .o_chunk_idx(o_chunk_idx), .o_row_max(o_row_max), .o_row_valid(o_row_valid),
    .i_row_ready(i_row_ready), .o_busy(o_busy), .o_err(o_err), .o_rows_done(o_rows_done)
  );

  typedef struct packed {
    logic [3:0]        n;
    logic [11:0][15:0] ch;
    logic [15:0]       exp_max;
  } vec_t;

  vec_t        vecs [7];
  vec_t        v;
  logic [15:0] exp_q [$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [7:0]  exp_rows = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check();
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard: row output with got 0x%0h expected none queued", o_row_max);
    end else begin
      check("row_max", 32'(o_row_max), 32'(exp_q.pop_front()));
    end
  endtask

  // Starts a row from IDLE, feeds every chunk, and checks the row is presented one cycle later.
  task automatic fill_row(input vec_t r);
    i_start = 1'b1;
    i_num_chunks = r.n;
    exp_q.push_back(r.exp_max);
    @(negedge i_clk);
    i_start = 1'b0;
    check("in_ready_accum", 32'(o_in_ready), 32'd1);
    check("busy_accum", 32'(o_busy), 32'd1);
    for (int k = 0; k < int'(r.n); k++) begin
      check("chunk_idx", 32'(o_chunk_idx), 32'(k));
      i_in_valid = 1'b1;
      i_loc_max = r.ch[k];
      @(negedge i_clk);
    end
    i_in_valid = 1'b0;
    check("row_valid_lat1", 32'(o_row_valid), 32'd1);
    check("in_ready_out", 32'(o_in_ready), 32'd0);
    pop_check();
  endtask

  task automatic release_row();
    i_row_ready = 1'b1;
    @(negedge i_clk);
    i_row_ready = 1'b0;
    exp_rows = exp_rows + 8'd1;
    check("rows_done", 32'(o_rows_done), 32'(exp_rows));
    check("busy_idle", 32'(o_busy), 32'd0);
    check("row_valid_idle", 32'(o_row_valid), 32'd0);
  endtask

  task automatic run_row(input vec_t r);
    fill_row(r);
    release_row();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_num_chunks = 4'd0; i_in_valid = 1'b0;
    i_loc_max = '0; i_row_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_row_max", 32'(o_row_max), 32'h8000);
    check("rst_rows_done", 32'(o_rows_done), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_in_ready", 32'(o_in_ready), 32'd0);
    check("rst_row_valid", 32'(o_row_valid), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_chunk_idx", 32'(o_chunk_idx), 32'd0);
    i_rst = 1'b0;

    for (int i = 0; i < 7; i++) vecs[i] = '0;
    vecs[0].n = 4'd3; vecs[0].ch[0] = 16'h0010; vecs[0].ch[1] = 16'hFFF0; vecs[0].ch[2] = 16'h0025;
    vecs[0].exp_max = 16'h0025;
    vecs[1].n = 4'd2; vecs[1].ch[0] = 16'h8000; vecs[1].ch[1] = 16'h8001; vecs[1].exp_max = 16'h8001;
    vecs[2].n = 4'd1; vecs[2].ch[0] = 16'h7FFF; vecs[2].exp_max = 16'h7FFF;
    vecs[3].n = 4'd4; vecs[3].ch[0] = 16'hFFFF; vecs[3].ch[1] = 16'hFFFE; vecs[3].ch[2] = 16'h8000;
    vecs[3].ch[3] = 16'hFFFD; vecs[3].exp_max = 16'hFFFF;
    vecs[4].n = 4'd4; vecs[4].ch[0] = 16'h0001; vecs[4].ch[1] = 16'h0005; vecs[4].ch[2] = 16'h0005;
    vecs[4].ch[3] = 16'h0003; vecs[4].exp_max = 16'h0005;
    vecs[5].n = 4'd2; vecs[5].ch[0] = 16'h8000; vecs[5].ch[1] = 16'h8000; vecs[5].exp_max = 16'h8000;
    vecs[6].n = 4'd12;
    for (int k = 0; k < 12; k++) vecs[6].ch[k] = 16'(k * 7 - 40);
    vecs[6].exp_max = 16'h0025;

    for (int i = 0; i < 7; i++) run_row(vecs[i]);

    // Illegal chunk counts from IDLE.
    i_start = 1'b1; i_num_chunks = 4'd0;
    @(negedge i_clk);
    i_start = 1'b0;
    check("err_n0_pulse", 32'(o_err), 32'd1);
    check("err_n0_ready", 32'(o_in_ready), 32'd0);
    check("err_n0_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    check("err_n0_clear", 32'(o_err), 32'd0);
    i_start = 1'b1; i_num_chunks = 4'd13;
    @(negedge i_clk);
    i_start = 1'b0;
    check("err_n13_pulse", 32'(o_err), 32'd1);
    check("err_n13_ready", 32'(o_in_ready), 32'd0);
    @(negedge i_clk);
    check("err_n13_clear", 32'(o_err), 32'd0);
    check("err_n13_busy", 32'(o_busy), 32'd0);
    check("err_rows_kept", 32'(o_rows_done), 32'(exp_rows));

    // Downstream stall: row held, chunks and starts ignored, then back-to-back restart.
    v = '0; v.n = 4'd2; v.ch[0] = 16'h0003; v.ch[1] = 16'h0002; v.exp_max = 16'h0003;
    fill_row(v);
    for (int i = 0; i < 5; i++) begin
      i_in_valid = i[0]; i_start = 1'b1; i_num_chunks = 4'd1; i_loc_max = 16'h7FFF;
      @(negedge i_clk);
      check("stall_row_max", 32'(o_row_max), 32'h0003);
      check("stall_valid", 32'(o_row_valid), 32'd1);
      check("stall_in_ready", 32'(o_in_ready), 32'd0);
    end
    i_in_valid = 1'b0; i_row_ready = 1'b1; i_start = 1'b1; i_num_chunks = 4'd1;
    exp_q.push_back(16'h0009);
    @(negedge i_clk);
    i_row_ready = 1'b0; i_start = 1'b0;
    exp_rows = exp_rows + 8'd1;
    check("b2b_rows_done", 32'(o_rows_done), 32'(exp_rows));
    check("b2b_accum", 32'(o_in_ready), 32'd1);
    check("b2b_chunk_idx", 32'(o_chunk_idx), 32'd0);
    i_in_valid = 1'b1; i_loc_max = 16'h0009;
    @(negedge i_clk);
    i_in_valid = 1'b0;
    check("b2b_valid", 32'(o_row_valid), 32'd1);
    pop_check();
    release_row();

    // Release with an illegal restart: error pulse, back to IDLE, row value kept.
    v = '0; v.n = 4'd1; v.ch[0] = 16'hFFF0; v.exp_max = 16'hFFF0;
    fill_row(v);
    i_row_ready = 1'b1; i_start = 1'b1; i_num_chunks = 4'd0;
    @(negedge i_clk);
    i_row_ready = 1'b0; i_start = 1'b0;
    exp_rows = exp_rows + 8'd1;
    check("out_err_pulse", 32'(o_err), 32'd1);
    check("out_err_busy", 32'(o_busy), 32'd0);
    check("out_err_rows", 32'(o_rows_done), 32'(exp_rows));
    @(negedge i_clk);
    check("out_err_clear", 32'(o_err), 32'd0);
    check("row_max_retained", 32'(o_row_max), 32'hFFF0);
    check("row_valid_low", 32'(o_row_valid), 32'd0);

    // Reset mid-row wins over a simultaneous chunk and start.
    i_start = 1'b1; i_num_chunks = 4'd4;
    @(negedge i_clk);
    i_start = 1'b0;
    i_in_valid = 1'b1; i_loc_max = 16'h0100;
    @(negedge i_clk);
    i_loc_max = 16'h0200;
    @(negedge i_clk);
    check("mid_chunk_idx", 32'(o_chunk_idx), 32'd2);
    i_rst = 1'b1; i_loc_max = 16'h7000; i_start = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0; i_in_valid = 1'b0; i_start = 1'b0;
    exp_rows = 8'd0;
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_row_max", 32'(o_row_max), 32'h8000);
    check("mid_rst_rows", 32'(o_rows_done), 32'd0);
    check("mid_rst_chunk_idx", 32'(o_chunk_idx), 32'd0);
    check("mid_rst_ready", 32'(o_in_ready), 32'd0);
    v = '0; v.n = 4'd1; v.ch[0] = 16'h0007; v.exp_max = 16'h0007;
    run_row(v);

    // 255 more single-chunk rows bring the counter through 255 back to 0.
    for (int i = 0; i < 255; i++) begin
      v = '0; v.n = 4'd1; v.ch[0] = 16'($urandom); v.exp_max = v.ch[0];
      run_row(v);
    end
    check("rows_wrap", 32'(o_rows_done), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/max_row_scheduler.md
MAX_ROW_SCHEDULER -- requirements
Module: max_row_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of the signed local/row max values.
REQ-002 SHALL have parameter MAX_CHUNKS, default 12, maximum number of chunks per row.
REQ-003 SHALL have ports as follows; reset is i_rst, synchronous, active-high, and the clock is i_clk:
  i_clk  in  1  clock, all state on rising edge
  i_rst  in  1  synchronous active-high reset
  i_start  in  1  row-start request, sampled in IDLE or in OUT while the row is being accepted
  i_num_chunks  in  4  chunks in the row, legal range 1..MAX_CHUNKS
  i_in_valid  in  1  chunk local max valid
  o_in_ready  out  1  scheduler accepts a chunk
  i_loc_max  in  DATA_W  signed local max of one chunk
  o_chunk_idx  out  4  index of the next chunk expected, 0-based
  o_row_max  out  DATA_W  signed max of the completed row
  o_row_valid  out  1  o_row_max valid
  i_row_ready  in  1  downstream accepts the row max
  o_busy  out  1  high in ACCUM or OUT
  o_err  out  1  one-cycle pulse on an illegal i_num_chunks at start
  o_rows_done  out  8  completed-row counter, wraps 255->0

Function
REQ-004 SHALL implement FSM states IDLE, ACCUM and OUT.
REQ-005 SHALL, in IDLE with i_start=1 and i_num_chunks in 1..MAX_CHUNKS, latch N=i_num_chunks, clear the chunk count, set acc=0x8000 (most negative) and enter ACCUM next cycle.
REQ-006 SHALL, in IDLE with i_start=1 and i_num_chunks equal to 0 or greater than MAX_CHUNKS, pulse o_err for exactly one cycle, remain in IDLE and leave all other state unchanged.
REQ-007 SHALL drive o_in_ready=1 only in ACCUM; a handshake is i_in_valid & o_in_ready.
REQ-008 SHALL, on each handshake, update acc to the signed max of acc and i_loc_max (ties keep acc) and increment the chunk count.
REQ-009 SHALL drive o_chunk_idx with the current chunk count; it is 0 outside ACCUM.
REQ-010 SHALL, on the handshake where the chunk count equals N-1, load o_row_max with the signed max of acc and i_loc_max, and enter OUT next cycle with o_row_valid=1.
REQ-011 SHALL hold o_row_max and o_row_valid stable in OUT until i_row_ready=1.
REQ-012 SHALL, in OUT with i_row_ready=1, increment o_rows_done and go to IDLE next cycle; if i_start=1 with a legal i_num_chunks in the same cycle, it SHALL instead go directly to ACCUM with the new N latched (zero-bubble back-to-back).
REQ-013 SHALL, in OUT with i_row_ready=1 and i_start=1 with an illegal i_num_chunks, pulse o_err and go to IDLE.
REQ-014 SHALL ignore i_start in ACCUM and in OUT when i_row_ready=0.
REQ-015 SHALL ignore i_in_valid outside ACCUM; no chunk is consumed.
REQ-016 SHALL drive o_row_valid=0 outside OUT, while o_row_max retains the last row value.
REQ-017 SHALL drive o_busy=1 in ACCUM and OUT, and 0 in IDLE.
REQ-018 SHALL, for N=1, complete the row on the first handshake, giving o_row_max equal to i_loc_max.
REQ-019 SHALL give a latency from the final chunk handshake to o_row_valid=1 of exactly 1 cycle.

Reset
REQ-020 SHALL, on i_rst=1 at a clock edge, force IDLE, o_row_max=0x8000, acc=0x8000, o_row_valid=0, o_in_ready=0, o_err=0, o_busy=0, o_chunk_idx=0 and o_rows_done=0, regardless of state, including mid-row.
REQ-021 SHALL give i_rst priority over every other input in the same cycle.

Verification
REQ-022 SHALL cover: start N=3, chunks 0x0010, 0xFFF0, 0x0025 each with valid=1 -> o_row_valid=1 one cycle after the third chunk, o_row_max=0x0025, o_rows_done=1.
REQ-023 SHALL cover: start N=2, chunks 0x8000, 0x8001 -> o_row_max=0x8001, confirming the signed compare.
REQ-024 SHALL cover: start with i_num_chunks=0, then with 13 -> o_err pulses one cycle each time, the FSM stays IDLE and o_in_ready stays 0.
REQ-025 SHALL cover: i_row_ready=0 held 5 cycles in OUT with i_in_valid toggling -> o_row_max stable and no chunk accepted; then i_row_ready=1 and i_start=1 with N=1 -> ACCUM next cycle, o_rows_done increments.
REQ-026 SHALL cover: i_rst asserted after 2 of 4 chunks -> next cycle IDLE, o_row_max=0x8000, o_rows_done=0; a new row N=1 with chunk 0x0007 yields o_row_max=0x0007.
REQ-027 SHALL cover: 256 rows of N=1 -> o_rows_done wraps to 0.
